// File: rtl/progcount_stack_if.sv
// progcount_stack_if: decoder-side control/target bus and PC/flag outputs
// of the progcount_stack program counter. The decoder side holds the master
// modport, and the program counter holds the slave modport.
interface progcount_stack_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] A;           // absolute target for Load/Call
  logic [WIDTH-1:0] Off;         // two's-complement branch offset
  logic             Load;
  logic             Call;
  logic             Ret;
  logic             Branch;
  logic             CountEn;
  logic [WIDTH-1:0] Y;           // current program counter
  logic             StackEmpty;
  logic             StackFull;
  logic             Err;

  modport master (
    output A, Off, Load, Call, Ret, Branch, CountEn,
    input  Y, StackEmpty, StackFull, Err
  );

  modport slave (
    input  A, Off, Load, Call, Ret, Branch, CountEn,
    output Y, StackEmpty, StackFull, Err
  );
endinterface

// File: rtl/progcount_stack.sv
// progcount_stack: parametrised program counter with a hardware
// return-address stack.
//
// Each cycle performs one action, chosen by fixed priority:
// Load > Call > Ret > Branch > CountEn > hold.
// Strobes of lower priority have no side effects.
//
// Optional feature macro: PROGCOUNT_STACK_EN
//   defined   : LIFO return stack, Call pushes Y+STEP, Ret pops,
//               StackEmpty/StackFull/Err reflect the stack pointer.
//   undefined : no stack storage; Call acts as Load, Ret holds,
//               StackEmpty=1, StackFull=0, Err=0.
module progcount_stack #(
  parameter int WIDTH       = 8,
  parameter int STEP        = 1,
  parameter int RESET_VEC   = 0,
  parameter int STACK_DEPTH = 4
) (
  input logic              Clk,
  input logic              nReset,
  progcount_stack_if.slave bus
);

  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VEC);

  typedef enum logic [2:0] {
    ACT_HOLD   = 3'd0,
    ACT_LOAD   = 3'd1,
    ACT_CALL   = 3'd2,
    ACT_RET    = 3'd3,
    ACT_BRANCH = 3'd4,
    ACT_COUNT  = 3'd5
  } action_t;

  action_t          action;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] seq_addr;   // sequential successor, also the return address

  assign seq_addr = pc + STEP_W;

  // Resolve concurrent strobes to the single highest-priority action.
  always_comb begin
    action = ACT_HOLD;
    if (bus.Load) begin
      action = ACT_LOAD;
    end else if (bus.Call) begin
      action = ACT_CALL;
    end else if (bus.Ret) begin
      action = ACT_RET;
    end else if (bus.Branch) begin
      action = ACT_BRANCH;
    end else if (bus.CountEn) begin
      action = ACT_COUNT;
    end else begin
      action = ACT_HOLD;
    end
  end

`ifdef PROGCOUNT_STACK_EN

  // SP counts entries 0..STACK_DEPTH, so it needs one state more than the
  // entry index does.
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_ZERO = {SP_W{1'b0}};
  localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);
  localparam logic [SP_W-1:0] SP_MAX  = SP_W'(STACK_DEPTH);

  logic [WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [SP_W-1:0]  sp;
  logic [SP_W-1:0]  sp_next;
  logic [SP_W-1:0]  sp_dec;
  logic [IDX_W-1:0] push_idx;
  logic [IDX_W-1:0] pop_idx;
  logic             push;
  logic             err;
  logic             err_next;
  logic             stack_empty;
  logic             stack_full;

  assign stack_empty = (sp == SP_ZERO);
  assign stack_full  = (sp == SP_MAX);
  assign sp_dec      = sp - SP_ONE;
  // Push happens only while SP < STACK_DEPTH, and pop only while SP > 0,
  // so both truncated indices always address a real entry.
  assign push_idx    = sp[IDX_W-1:0];
  assign pop_idx     = sp_dec[IDX_W-1:0];

  // Next PC, stack pointer and sticky error for the selected action.
  always_comb begin
    pc_next  = pc;
    sp_next  = sp;
    err_next = err;
    push     = 1'b0;
    case (action)
      ACT_LOAD: begin
        pc_next = bus.A;
      end
      ACT_CALL: begin
        if (!stack_full) begin
          push    = 1'b1;
          sp_next = sp + SP_ONE;
          pc_next = bus.A;
        end else begin
          err_next = 1'b1;
        end
      end
      ACT_RET: begin
        if (!stack_empty) begin
          sp_next = sp_dec;
          pc_next = stack_mem[pop_idx];
        end else begin
          err_next = 1'b1;
        end
      end
      ACT_BRANCH: begin
        pc_next = pc + bus.Off;
      end
      ACT_COUNT: begin
        pc_next = seq_addr;
      end
      ACT_HOLD: begin
        pc_next = pc;
      end
      default: begin
        pc_next = pc;
      end
    endcase
  end

  // PC, stack pointer and sticky error registers; reset empties the stack.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      pc  <= RESET_W;
      sp  <= SP_ZERO;
      err <= 1'b0;
    end else begin
      pc  <= pc_next;
      sp  <= sp_next;
      err <= err_next;
    end
  end

  // Return-address storage; contents are meaningless above SP, so no reset.
  always_ff @(posedge Clk) begin
    if (push) begin
      stack_mem[push_idx] <= seq_addr;
    end
  end

  assign bus.StackEmpty = stack_empty;
  assign bus.StackFull  = stack_full;
  assign bus.Err        = err;

`else

  // Next PC without a stack: Call degenerates to Load and Ret holds.
  always_comb begin
    pc_next = pc;
    case (action)
      ACT_LOAD: begin
        pc_next = bus.A;
      end
      ACT_CALL: begin
        pc_next = bus.A;
      end
      ACT_RET: begin
        pc_next = pc;
      end
      ACT_BRANCH: begin
        pc_next = pc + bus.Off;
      end
      ACT_COUNT: begin
        pc_next = seq_addr;
      end
      ACT_HOLD: begin
        pc_next = pc;
      end
      default: begin
        pc_next = pc;
      end
    endcase
  end

  // PC register.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      pc <= RESET_W;
    end else begin
      pc <= pc_next;
    end
  end

  // With no stack present, StackEmpty is always 1 and Err is always 0.
  // STACK_DEPTH is at least 1, so the StackFull comparison is always false.
  assign bus.StackEmpty = 1'b1;
  assign bus.StackFull  = (STACK_DEPTH == 0);
  assign bus.Err        = 1'b0;

`endif

  assign bus.Y = pc;

endmodule

// File: tb/tb_progcount_stack.sv
// tb_progcount_stack: self-checking bench for progcount_stack (WIDTH=8,
// STEP=1, RESET_VEC=0, STACK_DEPTH=4). A queue-based reference model follows
// PROGCOUNT_STACK_EN so the bench fits either build.
module tb_progcount_stack;

  localparam int WIDTH = 8;
  localparam int STEP  = 1;
  localparam int RVEC  = 0;
  localparam int DEPTH = 4;
`ifdef PROGCOUNT_STACK_EN
  localparam bit STACK_EN = 1'b1;
`else
  localparam bit STACK_EN = 1'b0;
`endif

  logic Clk;
  logic nReset;
  progcount_stack_if #(.WIDTH(WIDTH)) bus ();

  progcount_stack #(
    .WIDTH(WIDTH), .STEP(STEP), .RESET_VEC(RVEC), .STACK_DEPTH(DEPTH)
  ) dut (
    .Clk(Clk),
    .nReset(nReset),
    .bus(bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  // Reference model: PC as an integer modulo 256, stack as a queue.
  int m_y;
  int m_stack[$];
  bit m_err;

  function automatic void model_reset();
    m_y = RVEC;
    m_stack.delete();
    m_err = 1'b0;
  endfunction

  function automatic void model_apply(bit ld, bit cl, bit rt, bit br, bit ce, int a, int off);
    if (ld) m_y = a;
    else if (cl) begin
      if (!STACK_EN) m_y = a;
      else if (m_stack.size() == DEPTH) m_err = 1'b1;
      else begin
        m_stack.push_back((m_y + STEP) % 256);
        m_y = a;
      end
    end else if (rt) begin
      if (STACK_EN) begin
        if (m_stack.size() == 0) m_err = 1'b1;
        else m_y = m_stack.pop_back();
      end
    end else if (br) m_y = (m_y + off) % 256;
    else if (ce) m_y = (m_y + STEP) % 256;
  endfunction

  function automatic bit exp_empty();
    return STACK_EN ? (m_stack.size() == 0) : 1'b1;
  endfunction

  function automatic bit exp_full();
    return STACK_EN ? (m_stack.size() == DEPTH) : 1'b0;
  endfunction

  // Drive one cycle of strobes, advance the model, sample 1 time unit after the edge.
  task automatic do_cycle(input bit ld, input bit cl, input bit rt, input bit br,
                          input bit ce, input int a, input int off);
    bus.Load = ld; bus.Call = cl; bus.Ret = rt; bus.Branch = br; bus.CountEn = ce;
    bus.A = 8'(a); bus.Off = 8'(off);
    @(posedge Clk);
    model_apply(ld, cl, rt, br, ce, a, off);
    #1;
    bus.Load = 1'b0; bus.Call = 1'b0; bus.Ret = 1'b0; bus.Branch = 1'b0; bus.CountEn = 1'b0;
  endtask

  task automatic apply_reset();
    #2 nReset = 1'b0;
    model_reset();
    #3 nReset = 1'b1;
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    #1;
    total++; if (bus.Y !== 8'(RVEC)) begin bad++; $display("FAIL reset_y: got %0d want %0d", bus.Y, RVEC); end
    total++; if ({bus.StackEmpty, bus.StackFull, bus.Err} !== 3'b100) begin
      bad++; $display("FAIL reset_flags: got e/f/err=%b%b%b want 100", bus.StackEmpty, bus.StackFull, bus.Err);
    end
    model_reset();
    #3 nReset = 1'b1;
  endtask

  task automatic test_load_count();
    int want[3] = '{2, 3, 4};
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    total++; if (bus.Y !== 8'd1) begin bad++; $display("FAIL load_y: got %0d want 1", bus.Y); end
    do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 0);
    total++; if (bus.Y !== 8'd1) begin bad++; $display("FAIL idle_y: got %0d want 1", bus.Y); end
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
      total++; if (bus.Y !== 8'(want[i])) begin bad++; $display("FAIL count_y[%0d]: got %0d want %0d", i, bus.Y, want[i]); end
    end
  endtask

  task automatic test_wrap();
    int want[3] = '{255, 0, 1};
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 254, 0);
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
      total++; if (bus.Y !== 8'(want[i])) begin bad++; $display("FAIL wrap_y[%0d]: got %0d want %0d", i, bus.Y, want[i]); end
    end
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 8'hFE);
    total++; if (bus.Y !== 8'd255) begin bad++; $display("FAIL branch_back_y: got %0d want 255", bus.Y); end
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 8'h03);
    total++; if (bus.Y !== 8'd2) begin bad++; $display("FAIL branch_fwd_y: got %0d want 2", bus.Y); end
  endtask

  task automatic test_call_ret();
    int ops[5]  = '{0, 1, 1, 2, 2};   // 0 load, 1 call, 2 ret
    int args[5] = '{10, 40, 80, 0, 0};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      do_cycle(ops[i] == 0, ops[i] == 1, ops[i] == 2, 1'b0, 1'b0, args[i], 0);
      total++; if (bus.Y !== 8'(m_y)) begin bad++; $display("FAIL callret_y[%0d]: got %0d want %0d", i, bus.Y, m_y); end
    end
    total++; if ({bus.StackEmpty, bus.Err} !== {exp_empty(), m_err}) begin
      bad++; $display("FAIL callret_flags: got empty/err=%b%b want %b%b", bus.StackEmpty, bus.Err, exp_empty(), m_err);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      do_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, (i == 4) ? 99 : 20 + 10 * i, 0);
      total++; if ({bus.Y, bus.StackFull, bus.Err} !== {8'(m_y), exp_full(), m_err}) begin
        bad++; $display("FAIL ovf_call[%0d]: got y=%0d full=%b err=%b want y=%0d full=%b err=%b",
                        i, bus.Y, bus.StackFull, bus.Err, m_y, exp_full(), m_err);
      end
    end
    for (int i = 0; i < 5; i++) begin
      do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
      total++; if ({bus.Y, bus.StackEmpty, bus.Err} !== {8'(m_y), exp_empty(), m_err}) begin
        bad++; $display("FAIL unf_ret[%0d]: got y=%0d empty=%b err=%b want y=%0d empty=%b err=%b",
                        i, bus.Y, bus.StackEmpty, bus.Err, m_y, exp_empty(), m_err);
      end
    end
  endtask

  task automatic test_priority();
    apply_reset();
    do_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 7, 0);
    total++; if ({bus.Y, bus.StackEmpty} !== {8'd7, 1'b1}) begin
      bad++; $display("FAIL prio_load: got y=%0d empty=%b want y=7 empty=1", bus.Y, bus.StackEmpty);
    end
    do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0);
    total++; if ({bus.Y, bus.Err} !== {8'd7, m_err}) begin
      bad++; $display("FAIL prio_ret_count: got y=%0d err=%b want y=7 err=%b", bus.Y, bus.Err, m_err);
    end
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 16);
    total++; if (bus.Y !== 8'd23) begin bad++; $display("FAIL prio_branch_count: got %0d want 23", bus.Y); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    do_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 50, 0);
    do_cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 60, 0);
    #2 nReset = 1'b0;
    #1;
    total++; if ({bus.Y, bus.StackEmpty, bus.Err} !== {8'(RVEC), 1'b1, 1'b0}) begin
      bad++; $display("FAIL async_reset: got y=%0d empty=%b err=%b want y=%0d empty=1 err=0",
                      bus.Y, bus.StackEmpty, bus.Err, RVEC);
    end
    model_reset();
    #2 nReset = 1'b1;
    do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    total++; if ({bus.Y, bus.Err} !== {8'(m_y), m_err}) begin
      bad++; $display("FAIL post_reset_ret: got y=%0d err=%b want y=%0d err=%b", bus.Y, bus.Err, m_y, m_err);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    do_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 30, 0);
    for (int i = 0; i < 6; i++) begin
      do_cycle(1'b0, i % 2 == 0, i % 2 == 1, 1'b0, 1'b0, 100 + i, 0);
      total++; if (bus.Y !== 8'(m_y)) begin bad++; $display("FAIL b2b_y[%0d]: got %0d want %0d", i, bus.Y, m_y); end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      do_cycle($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
               $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0,
               int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      total++;
      if ({bus.Y, bus.StackEmpty, bus.StackFull, bus.Err} !== {8'(m_y), exp_empty(), exp_full(), m_err}) begin
        bad++; $display("FAIL rand[%0d]: got y=%0d e/f/err=%b%b%b want y=%0d e/f/err=%b%b%b", i, bus.Y,
                        bus.StackEmpty, bus.StackFull, bus.Err, m_y, exp_empty(), exp_full(), m_err);
      end
    end
  endtask

  initial begin
    nReset = 1'b0;
    bus.A = 8'd0; bus.Off = 8'd0;
    bus.Load = 1'b0; bus.Call = 1'b0; bus.Ret = 1'b0; bus.Branch = 1'b0; bus.CountEn = 1'b0;
    model_reset();
    test_reset();
    test_load_count();
    test_wrap();
    test_call_ret();
    test_overflow();
    test_priority();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/progcount_stack.md
# progcount_stack

Parametrised program counter with a hardware return-address stack, the next generation of the team's 8-bit load/count program counter. Adds configurable width and step, reset vector, signed relative branch, and call/return through an on-chip LIFO. Sits between the instruction decoder (source of control strobes and target/offset values) and the instruction memory address port (driven by `Y`).

## Interface
- `WIDTH`, 8: counter and address width in bits.
- `STEP`, 1: increment applied on count and used for the return address; must be less than 2^WIDTH.
- `RESET_VEC`, 0: value of `Y` after reset.
- `STACK_DEPTH`, 4: return-stack entries, 1 to 16.

- `Clk` in 1: clock; all state updates on rising edge.
- `nReset` in 1: asynchronous, active-low reset.
- `A` in WIDTH: absolute target for Load/Call.
- `Off` in WIDTH: two's-complement branch offset.
- `Load` in 1: jump to `A`.
- `Call` in 1: push return address, jump to `A`.
- `Ret` in 1: pop return address into `Y`.
- `Branch` in 1: `Y <= Y + Off`.
- `CountEn` in 1: `Y <= Y + STEP`.
- `Y` out WIDTH: current program counter, registered.
- `StackEmpty` out 1: stack holds zero entries.
- `StackFull` out 1: stack holds STACK_DEPTH entries.
- `Err` out 1: sticky stack overflow/underflow flag.

## Operation
- One action per cycle, fixed priority: Load > Call > Ret > Branch > CountEn > hold. Lower-priority strobes asserted together are ignored entirely (no push/pop side effects).
- Load: `Y <= A`; stack untouched.
- Call, stack not full: `stack[SP] <= Y + STEP` (mod 2^WIDTH), `SP <= SP + 1`, `Y <= A`.
- Call, stack full: `Y` holds, `SP` holds, no entry written, `Err <= 1`.
- Ret, stack not empty: `SP <= SP - 1`, `Y <= stack[SP-1]`.
- Ret, stack empty: `Y` holds, `Err <= 1`.
- Branch: `Y <= Y + Off`, truncated to WIDTH (modulo wrap both directions).
- CountEn: `Y <= Y + STEP`, modulo 2^WIDTH; e.g. WIDTH=8, STEP=1: 255 -> 0.
- No strobe: all state holds.
- `Err` clears only on reset.
- `SP` range 0..STACK_DEPTH; `StackEmpty = (SP==0)`, `StackFull = (SP==STACK_DEPTH)`, both combinational from registered `SP`.

## Timing
- Reset (`nReset`=0, asynchronous, immediate): `Y = RESET_VEC`, `SP = 0`, `StackEmpty = 1`, `StackFull = 0`, `Err = 0`. Stack contents need not be cleared.
- Deassertion: first action taken on the first rising edge with `nReset`=1.
- Latency: every action visible on `Y` one cycle after the sampling edge; flags update on the same edge.
- Back-to-back Call/Ret every cycle supported with no bubbles; Ret immediately after Call returns the just-pushed address.
- Reset mid-sequence discards all stack entries; a following Ret is an underflow.

## Configuration
- `PROGCOUNT_STACK_EN` defined: return stack, `Call`/`Ret` behaviour and flags as above.
- Undefined: no stack storage or `SP`. `Call` behaves as `Load` (jump to `A`, no push); `Ret` is ignored (hold, lower-priority strobes still ignored); `StackEmpty` tied 1, `StackFull` tied 0, `Err` tied 0. All other behaviour identical.

## Test plan
- Reset/load/count (WIDTH=8, RESET_VEC=0): `nReset`=0 -> `Y`=0, `StackEmpty`=1; release, Load A=1 -> Y=1; idle with A=3 -> Y stays 1; CountEn 3 cycles -> 2,3,4.
- Wrap: Load A=254, CountEn 3 cycles -> 255, 0, 1; Branch Off=8'hFE from Y=1 -> 255.
- Call/Ret nesting (DEPTH=4): from Y=10, Call A=40 -> Y=40, SP=1; Call A=80 -> Y=80; Ret -> 41; Ret -> 11, `StackEmpty`=1, `Err`=0.
- Overflow/underflow: 4 Calls -> `StackFull`=1; 5th Call A=99 -> Y unchanged, `Err`=1; 5 Rets -> last Ret holds Y, `Err` stays 1 until `nReset`.
- Priority: Load A=7 + Call A=9 + CountEn same cycle -> Y=7, SP unchanged; Ret + CountEn with stack empty -> Y holds, `Err`=1.
- Async reset mid-operation: assert `nReset` between edges after 2 Calls -> `Y`=RESET_VEC immediately, `StackEmpty`=1; macro-off build: Call A=20 -> Y=20, Ret -> hold, `Err`=0.
